imem_stream_loader: RTL and testbench

- Parametrised successor to the fixed-content instruction memory.
- Byte-addressed, big-endian, word-organised instruction store.
- Contents are written at run time by a streaming loader port, not by an initial block.
- Fetches are registered (1-cycle latency) with a valid/stall handshake, and fault reporting covers misaligned and out-of-program addresses.
- Sits between the PC/fetch stage and the decode stage; the loader side is driven by the bench or boot logic.

---
 rtl/imem_stream_loader.sv | 71 +++++++
 tb/tb_imem_stream_loader.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: run-time loadable, big-endian word instruction store
// with a registered, fault-checked fetch port and valid/stall handshake.
module imem_stream_loader #(
  parameter int WORDS = 16,
  parameter int ADDR_W = 64,
  localparam int PTR_W = $clog2(WORDS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_en,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [31:0]       instruction,
  output logic              fetch_fault,
  output logic              load_overflow,
  output logic [PTR_W-1:0]  prog_len
);
  localparam int IDX_W = $clog2(WORDS);
  typedef enum logic {LOAD, RUN} state_t;
  state_t state, state_nx;
  logic [31:0] mem [WORDS];
  logic [PTR_W-1:0] load_ptr;
  logic [ADDR_W-1:0] limit;
  logic room, wr, accept, fault;
  assign room = load_ptr < PTR_W'(WORDS);
  assign wr = state == LOAD && load_en && !load_start;
  // full-width compare so any set upper address bit faults
  assign limit = ADDR_W'({prog_len, 2'b00});
  assign fault = (|fetch_addr[1:0]) || fetch_addr >= limit;
  assign accept = fetch_req && fetch_ready;
  always_comb begin
    state_nx = load_start ? LOAD : (wr && load_last) ? RUN : state;
    fetch_ready = state == RUN && !load_start && !(instr_valid && fetch_stall);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOAD;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      load_ptr <= '0;
      prog_len <= '0;
      load_overflow <= 1'b0;
    end else if (load_start) begin
      load_ptr <= '0;
      prog_len <= '0;
      load_overflow <= 1'b0;
    end else if (wr) begin
      load_ptr <= room ? load_ptr + PTR_W'(1) : load_ptr;
      load_overflow <= load_overflow | !room;
      if (load_last) prog_len <= room ? load_ptr + PTR_W'(1) : PTR_W'(WORDS);
    end
  always_ff @(posedge clk)
    if (wr && room) mem[load_ptr[IDX_W-1:0]] <= load_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instruction <= '0;
      fetch_fault <= 1'b0;
    end else if (load_start) instr_valid <= 1'b0;
    else if (accept) begin
      instr_valid <= 1'b1;
      instruction <= fault ? '0 : mem[fetch_addr[IDX_W+1:2]];
      fetch_fault <= fault;
    end else if (!(instr_valid && fetch_stall)) instr_valid <= 1'b0;
endmodule

// File: tb/tb_imem_stream_loader.sv
// tb_imem_stream_loader: directed vector table plus hand sequences for
// loading, overflow, stall, reload and asynchronous reset.
module tb_imem_stream_loader;
  logic clk = 0, rst_n = 0;
  logic load_start = 0, load_en = 0, load_last = 0;
  logic [31:0] load_data = 0;
  logic fetch_req = 0, fetch_stall = 0;
  logic [63:0] fetch_addr = 0;
  logic fetch_ready, instr_valid, fetch_fault, load_overflow;
  logic [31:0] instruction;
  logic [4:0] prog_len;
  int n_chk = 0, n_fail = 0;
  imem_stream_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_en(load_en),
    .load_data(load_data), .load_last(load_last), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_stall(fetch_stall), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instruction(instruction), .fetch_fault(fetch_fault),
    .load_overflow(load_overflow), .prog_len(prog_len)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic req; logic [63:0] addr; logic stall;
    logic rdy; logic v; logic [31:0] ins; logic f; logic ci;
  } vec_t;
  vec_t tv[15];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic start();
    load_start = 1; tick(); load_start = 0;
  endtask
  task automatic load_word(input logic [31:0] w, input logic last);
    load_en = 1; load_data = w; load_last = last; tick();
    load_en = 0; load_last = 0;
  endtask
  task automatic fetch(input string name, input logic [63:0] a, input logic [31:0] ins, input logic f);
    fetch_req = 1; fetch_addr = a; #1;
    chk({name, "_ready"}, fetch_ready, 1);
    tick(); fetch_req = 0;
    chk({name, "_valid"}, instr_valid, 1);
    chk({name, "_instr"}, instruction, ins);
    chk({name, "_fault"}, fetch_fault, f);
  endtask
  initial begin
    tv[0]  = '{1, 64'h0, 0, 1, 1, 32'hF8400142, 0, 1};
    tv[1]  = '{1, 64'h4, 0, 1, 1, 32'hF8401143, 0, 1};
    tv[2]  = '{1, 64'h8, 0, 1, 1, 32'hCB020064, 0, 1};
    tv[3]  = '{1, 64'hC, 0, 1, 1, 32'h8B020065, 0, 1};
    tv[4]  = '{1, 64'h10, 0, 1, 1, 32'h0, 1, 1};
    tv[5]  = '{1, 64'h6, 0, 1, 1, 32'h0, 1, 1};
    tv[6]  = '{1, 64'h1_0000_0000, 0, 1, 1, 32'h0, 1, 1};
    tv[7]  = '{1, 64'h4, 0, 1, 1, 32'hF8401143, 0, 1};
    tv[8]  = '{1, 64'h0, 1, 0, 1, 32'hF8401143, 0, 1};
    tv[9]  = '{1, 64'h0, 1, 0, 1, 32'hF8401143, 0, 1};
    tv[10] = '{1, 64'h0, 1, 0, 1, 32'hF8401143, 0, 1};
    tv[11] = '{1, 64'h8, 0, 1, 1, 32'hCB020064, 0, 1};
    tv[12] = '{0, 64'h0, 0, 1, 0, 32'h0, 0, 0};
    tv[13] = '{0, 64'h0, 1, 1, 0, 32'h0, 0, 0};
    tv[14] = '{1, 64'h3, 0, 1, 1, 32'h0, 1, 1};
    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_ovf", load_overflow, 0);
    chk("rst_len", prog_len, 0);
    chk("rst_ready", fetch_ready, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    tick();
    start();
    load_word(32'hF8400142, 0);
    load_word(32'hF8401143, 0);
    load_word(32'hCB020064, 0);
    chk("load_ready", fetch_ready, 0);
    load_word(32'h8B020065, 1);
    chk("load4_len", prog_len, 4);
    chk("load4_ovf", load_overflow, 0);
    chk("run_ready", fetch_ready, 1);
    for (int i = 0; i < 15; i++) begin
      fetch_req = tv[i].req; fetch_addr = tv[i].addr; fetch_stall = tv[i].stall; #1;
      chk($sformatf("tv%0d_ready", i), fetch_ready, tv[i].rdy);
      tick();
      chk($sformatf("tv%0d_valid", i), instr_valid, tv[i].v);
      if (tv[i].ci) begin
        chk($sformatf("tv%0d_instr", i), instruction, tv[i].ins);
        chk($sformatf("tv%0d_fault", i), fetch_fault, tv[i].f);
      end
    end
    fetch_req = 0; fetch_stall = 0;
    fetch("hold_pre", 64'h4, 32'hF8401143, 0);
    fetch_stall = 1; tick();
    chk("hold_valid", instr_valid, 1);
    load_start = 1; #1;
    chk("ls_ready_now", fetch_ready, 0);
    tick(); load_start = 0;
    chk("ls_valid", instr_valid, 0);
    chk("ls_ready", fetch_ready, 0);
    chk("ls_len", prog_len, 0);
    fetch_stall = 0;
    load_word(32'h14000003, 1);
    chk("reload_len", prog_len, 1);
    fetch("reload0", 64'h0, 32'h14000003, 0);
    fetch("reload4", 64'h4, 32'h0, 1);
    start();
    for (int i = 0; i < 18; i++) begin
      load_word(32'hA000_0000 + 32'(i), i == 17);
      if (i == 15) chk("ovf_w16", load_overflow, 0);
      if (i == 16) chk("ovf_w17", load_overflow, 1);
    end
    chk("ovf_flag", load_overflow, 1);
    chk("ovf_len", prog_len, 16);
    fetch("ovf_m15", 64'h3C, 32'hA000000F, 0);
    fetch("ovf_m0", 64'h0, 32'hA0000000, 0);
    fetch("ovf_end", 64'h40, 32'h0, 1);
    fetch("ovf_m15b", 64'h3C, 32'hA000000F, 0);
    start();
    chk("ls_ovf_clr", load_overflow, 0);
    for (int i = 0; i < 17; i++) load_word(32'hB000_0000 + 32'(i), 0);
    chk("mid_ovf", load_overflow, 1);
    #2 rst_n = 0; #1;
    chk("arst_ovf", load_overflow, 0);
    chk("arst_instr", instruction, 0);
    chk("arst_len", prog_len, 0);
    chk("arst_valid", instr_valid, 0);
    @(posedge clk); #3 rst_n = 1;
    tick();
    chk("arst_ready", fetch_ready, 0);
    load_word(32'h11111111, 0);
    load_word(32'h22222222, 1);
    chk("post_len", prog_len, 2);
    fetch("post0", 64'h0, 32'h11111111, 0);
    fetch("post4", 64'h4, 32'h22222222, 0);
    fetch("post8", 64'h8, 32'h0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
